rotary_counter_bank: RTL and testbench
======================================

// Module: rotary_counter_bank
// PURPOSE
//  N-channel quadrature rotary-encoder front end with per-channel counters. Each channel
//  synchronises and debounces its A/B/push-button pins, decodes quadrature (x1 detent or x4
//  edge mode), and steps a bounded counter in wrap or saturate mode. One channel is muxed to
//  the 8 board LEDs. Sits between the encoder header pins and the user-interface logic.
// PARAMETERS
//  N_CH       2   number of encoder channels (1..8)
//  WIDTH      8   counter width in bits (2..16)
//  MIN_VAL    0   lower count bound (unsigned)
//  MAX_VAL    255 upper count bound; MIN_VAL < MAX_VAL <= 2**WIDTH-1
//  RESET_VAL  0   value loaded on reset/button press; MIN_VAL <= RESET_VAL <= MAX_VAL
//  STEP       1   count increment per decoded event; 1 <= STEP <= MAX_VAL-MIN_VAL
//  WRAP       1   1 = modular wrap within [MIN_VAL,MAX_VAL]; 0 = saturate at bounds
//  QUAD_X4    0   0 = one event per detent (x1); 1 = one event per valid edge (x4)
//  DEBOUNCE   16  cycles a synced input must be stable before acceptance; 0 = bypass
// PORTS
//  CLK_i    in   1            system clock
//  RSTn_i   in   1            synchronous reset, active low
//  A_i      in   N_CH         encoder phase A per channel (async)
//  B_i      in   N_CH         encoder phase B per channel (async)
//  BTN_i    in   N_CH         push button per channel, active low (async)
//  SEL_i    in   3            channel shown on LED_o
//  CNT_o    out  N_CH*WIDTH   packed counts; channel k at [k*WIDTH +: WIDTH]
//  EVT_o    out  N_CH         1-cycle pulse per decoded rotation event
//  DIR_o    out  N_CH         direction of last event: 1 = up (forward), 0 = down
//  BTN_o    out  N_CH         debounced button level, 1 = pressed
//  LED_o    out  8            CNT of channel SEL_i, bits [7:0], zero-extended if WIDTH<8
// BEHAVIOUR
//  Reset (RSTn_i low at a CLK_i edge): CNT=RESET_VAL all channels, EVT=0, DIR=0, BTN_o=0;
//   A/B sync+debounced state=2'b00, BTN sync+debounced=1 (released); debounce counters=0.
//  Sync: 2-FF synchroniser per pin. Debounce: per pin, counter runs while synced != debounced,
//   clears when equal; debounced loads synced value after DEBOUNCE consecutive differing
//   cycles. DEBOUNCE=0: debounced register loads synced value every cycle.
//  Latency: stable input change -> debounced state after 3+DEBOUNCE edges; CNT/EVT/DIR update
//   on the next edge (4+DEBOUNCE total). EVT_o asserts in the same cycle CNT_o shows new value.
//  Decode on debounced {A,B}, prev vs current: forward seq 00->10->11->01->00, reverse is the
//   inverse. No change: no event. Both bits change (invalid): no event, prev updated anyway.
//   x4: every valid transition is an event. x1: event only on valid arrival at 00;
//   from 01 = up, from 10 = down.
//  Counter arithmetic in WIDTH+1 bits. Up: c+STEP > MAX_VAL -> WRAP ? c+STEP-(MAX_VAL-MIN_VAL+1)
//   : MAX_VAL. Down: c-STEP < MIN_VAL -> WRAP ? c-STEP+(MAX_VAL-MIN_VAL+1) : MIN_VAL.
//  Saturated event still pulses EVT_o and updates DIR_o; CNT unchanged.
//  Button: debounced 1->0 transition of BTN (press) loads CNT=RESET_VAL, no EVT. A rotation
//   event in the same cycle is discarded (button wins) but DIR_o still updates.
//  Channels fully independent; simultaneous events on different channels all apply.
//  SEL_i >= N_CH -> LED_o = 8'h00. LED_o is combinational from registered CNT.
//  Reset mid-debounce or mid-sequence: all partial state discarded; first valid transition
//   after reset is evaluated from prev state 00 (resting 11 seen after reset = invalid, no event).
// TESTING
//  1 Reset, DEBOUNCE=0, x1: ch0 drive 00->10->11->01->00 -> one EVT, CNT0 0->1, DIR0=1, at
//    edge 4 after final pin change; reverse sequence -> CNT0 back to 0, DIR0=0.
//  2 x4 mode, WRAP=1, MIN=0, MAX=255: 4 reverse edges from CNT=0 -> CNT 255,254,253,252.
//  3 WRAP=0, MAX=10, STEP=3, CNT=9: one up detent -> CNT=10, EVT pulses; another -> stays 10.
//  4 DEBOUNCE=16: 10-cycle glitches on A0 -> no state change; 20-cycle stable level -> accepted
//    after 3+16 edges.
//  5 CNT1=37, BTN1 pressed same cycle an up event debounces -> CNT1=RESET_VAL, EVT1=0;
//    ch0 counting concurrently unaffected.
//  6 SEL_i=1 -> LED_o=CNT1[7:0]; SEL_i=7 with N_CH=2 -> LED_o=0; RSTn_i low mid-sequence ->
//    all CNT=RESET_VAL, encoder resting at 11 afterwards -> no spurious EVT.

Source files
------------

// File: rtl/rotary_counter_bank.sv
// rotary_counter_bank
//   N-channel quadrature rotary-encoder front end. Each channel has three input pins: A, B and
//   an active-low push button. Every pin goes through a 2-FF synchroniser and then a debouncer.
//   The debounced A/B pair is quadrature-decoded in x1 (detent) or x4 (edge) mode, and each
//   decoded event steps a bounded counter that either wraps or saturates. A debounced button
//   press reloads the counter. One channel's count is muxed to the 8 LEDs.
// Ports
//   CLK_i   system clock
//   RSTn_i  synchronous reset, active low
//   A_i     encoder phase A per channel (async)
//   B_i     encoder phase B per channel (async)
//   BTN_i   push button per channel, active low (async)
//   SEL_i   channel shown on LED_o
//   CNT_o   packed counts, channel k at [k*WIDTH +: WIDTH]
//   EVT_o   one-cycle pulse per applied or saturated rotation event
//   DIR_o   direction of the last event, 1 = up
//   BTN_o   debounced button level, 1 = pressed
//   LED_o   low 8 bits of the selected count, zero when SEL_i >= N_CH
module rotary_counter_bank #(
   parameter int N_CH      = 2,
   parameter int WIDTH     = 8,
   parameter int MIN_VAL   = 0,
   parameter int MAX_VAL   = 255,
   parameter int RESET_VAL = 0,
   parameter int STEP      = 1,
   parameter int WRAP      = 1,
   parameter int QUAD_X4   = 0,
   parameter int DEBOUNCE  = 16
) (
   input  logic                    CLK_i,
   input  logic                    RSTn_i,
   input  logic [N_CH-1:0]         A_i,
   input  logic [N_CH-1:0]         B_i,
   input  logic [N_CH-1:0]         BTN_i,
   input  logic [2:0]              SEL_i,
   output logic [N_CH*WIDTH-1:0]   CNT_o,
   output logic [N_CH-1:0]         EVT_o,
   output logic [N_CH-1:0]         DIR_o,
   output logic [N_CH-1:0]         BTN_o,
   output logic [7:0]              LED_o
);

   localparam int DBW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [DBW-1:0] DB_LOAD = DBW'(DEBOUNCE);

   // One extra bit so c+STEP and c+RANGE cannot overflow.
   localparam int CW = WIDTH + 1;
   localparam logic [CW-1:0] MIN_C   = CW'(MIN_VAL);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_VAL);
   localparam logic [CW-1:0] STEP_C  = CW'(STEP);
   localparam logic [CW-1:0] RANGE_C = CW'(MAX_VAL - MIN_VAL + 1);
   localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

   // Bit positions within a channel's pin bundle; reset level has the button released.
   localparam int P_A   = 0;
   localparam int P_B   = 1;
   localparam int P_BTN = 2;
   localparam logic [2:0] PIN_RST = 3'b100;

   // Position of {A,B} along the forward cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] quad_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b10:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] step_cnt(input logic [WIDTH-1:0] cur, input logic up);
      logic [CW-1:0] c;
      logic [CW-1:0] r;
      c = {1'b0, cur};
      if (up) begin
         r = c + STEP_C;
         if (r > MAX_C) r = (WRAP != 0) ? (r - RANGE_C) : MAX_C;
      end else if (c < MIN_C + STEP_C) begin
         r = (WRAP != 0) ? (c + RANGE_C - STEP_C) : MIN_C;
      end else begin
         r = c - STEP_C;
      end
      return WIDTH'(r);
   endfunction

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic [2:0]       pin_raw;
      logic [2:0]       meta_q, sync_q;
      logic [2:0]       deb_q, deb_d;
      logic [DBW-1:0]   tmr_q [3];
      logic [DBW-1:0]   tmr_d [3];
      logic [1:0]       ab_prev_q, ab_prev_d, ab_cur, delta;
      logic             btn_prev_q, btn_prev_d;
      logic             evt_q, evt_d, dir_q, dir_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             fwd, rev, rot_evt, press;

      assign pin_raw = {BTN_i[ch], B_i[ch], A_i[ch]};

      // Down-counting stability timer per pin: reloaded whenever the synced and debounced
      // levels agree, terminal count reached after DEBOUNCE differing cycles, so the next
      // differing cycle is the one that accepts the new level.
      always_comb begin
         deb_d = deb_q;
         for (int p = 0; p < 3; p++) begin
            tmr_d[p] = tmr_q[p];
            if (DEBOUNCE == 0) begin
               deb_d[p] = sync_q[p];
               tmr_d[p] = DB_LOAD;
            end else if (sync_q[p] != deb_q[p]) begin
               if (tmr_q[p] == '0) begin
                  deb_d[p] = sync_q[p];
                  tmr_d[p] = DB_LOAD;
               end else begin
                  tmr_d[p] = tmr_q[p] - 1'b1;
               end
            end else begin
               tmr_d[p] = DB_LOAD;
            end
         end
      end

      always_comb begin
         ab_cur     = {deb_q[P_A], deb_q[P_B]};
         delta      = quad_pos(ab_cur) - quad_pos(ab_prev_q);
         fwd        = (delta == 2'd1);
         rev        = (delta == 2'd3);
         rot_evt    = (QUAD_X4 != 0) ? (fwd | rev) : ((ab_cur == 2'b00) && (fwd | rev));
         press      = btn_prev_q & ~deb_q[P_BTN];
         ab_prev_d  = ab_cur;
         btn_prev_d = deb_q[P_BTN];
         evt_d      = 1'b0;
         dir_d      = dir_q;
         cnt_d      = cnt_q;
         if (rot_evt) dir_d = fwd;
         // A press overrides any rotation landing in the same cycle.
         if (press) begin
            cnt_d = RESET_C;
         end else if (rot_evt) begin
            evt_d = 1'b1;
            cnt_d = step_cnt(cnt_q, fwd);
         end
      end

      always_ff @(posedge CLK_i) begin
         if (!RSTn_i) begin
            meta_q     <= PIN_RST;
            sync_q     <= PIN_RST;
            deb_q      <= PIN_RST;
            for (int p = 0; p < 3; p++) tmr_q[p] <= DB_LOAD;
            ab_prev_q  <= 2'b00;
            btn_prev_q <= 1'b1;
            evt_q      <= 1'b0;
            dir_q      <= 1'b0;
            cnt_q      <= RESET_C;
         end else begin
            meta_q     <= pin_raw;
            sync_q     <= meta_q;
            deb_q      <= deb_d;
            for (int p = 0; p < 3; p++) tmr_q[p] <= tmr_d[p];
            ab_prev_q  <= ab_prev_d;
            btn_prev_q <= btn_prev_d;
            evt_q      <= evt_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
         end
      end

      assign CNT_o[ch*WIDTH +: WIDTH] = cnt_q;
      assign EVT_o[ch]                = evt_q;
      assign DIR_o[ch]                = dir_q;
      assign BTN_o[ch]                = ~deb_q[P_BTN];
   end

   always_comb begin
      LED_o = 8'h00;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (int'(SEL_i) == ch) LED_o = 8'(CNT_o[ch*WIDTH +: WIDTH]);
      end
   end

endmodule

// File: tb/tb_rotary_counter_bank.sv
module tb_rotary_counter_bank;
   localparam int M0_MIN   = 0;
   localparam int M0_MAX   = 255;
   localparam int M0_RST   = 0;
   localparam int M0_STEP  = 1;
   localparam int M0_RANGE = M0_MAX - M0_MIN + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  a0, b0, btn0, a1, b1, btn1, a2, b2, btn2;
   logic [2:0]  sel0, sel1, sel2;
   logic [15:0] cnt0, cnt1, cnt2;
   logic [1:0]  evt0, evt1, evt2, dir0, dir1, dir2, bo0, bo1, bo2;
   logic [7:0]  led0, led1, led2;

   int tests = 0;
   int fails = 0;

   // Reference model for u_dut0: count, last seen gray position, event total, direction.
   int   m_cnt[2];
   int   m_pos[2];
   int   m_evt[2];
   logic m_dir[2];
   int   seen0[2] = '{0, 0};
   int   seen2 = 0;

   rotary_counter_bank #(.N_CH(2), .WIDTH(8), .MIN_VAL(M0_MIN), .MAX_VAL(M0_MAX),
      .RESET_VAL(M0_RST), .STEP(M0_STEP), .WRAP(1), .QUAD_X4(0), .DEBOUNCE(0)) u_dut0 (
      .CLK_i(clk), .RSTn_i(rst_n), .A_i(a0), .B_i(b0), .BTN_i(btn0), .SEL_i(sel0),
      .CNT_o(cnt0), .EVT_o(evt0), .DIR_o(dir0), .BTN_o(bo0), .LED_o(led0));

   rotary_counter_bank #(.N_CH(2), .WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .RESET_VAL(0),
      .STEP(1), .WRAP(1), .QUAD_X4(1), .DEBOUNCE(0)) u_dut1 (
      .CLK_i(clk), .RSTn_i(rst_n), .A_i(a1), .B_i(b1), .BTN_i(btn1), .SEL_i(sel1),
      .CNT_o(cnt1), .EVT_o(evt1), .DIR_o(dir1), .BTN_o(bo1), .LED_o(led1));

   rotary_counter_bank #(.N_CH(2), .WIDTH(8), .MIN_VAL(0), .MAX_VAL(10), .RESET_VAL(0),
      .STEP(3), .WRAP(0), .QUAD_X4(0), .DEBOUNCE(16)) u_dut2 (
      .CLK_i(clk), .RSTn_i(rst_n), .A_i(a2), .B_i(b2), .BTN_i(btn2), .SEL_i(sel2),
      .CNT_o(cnt2), .EVT_o(evt2), .DIR_o(dir2), .BTN_o(bo2), .LED_o(led2));

   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) if (evt0[ch] === 1'b1) seen0[ch]++;
      if (evt2[0] === 1'b1) seen2++;
   end

   // {A,B} at gray position p of the forward cycle 00,10,11,01
   function automatic logic [1:0] ab_of(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Move u_dut0 channel ch to gray position p (optionally pressing the button at the same
   // moment) and advance the model by the x1 rules.
   task automatic drive0(input int ch, input int p, input bit press);
      logic [1:0] ab;
      int d;
      ab = ab_of(p);
      d  = (p - m_pos[ch] + 4) % 4;
      a0[ch] = ab[1];
      b0[ch] = ab[0];
      if (press) btn0[ch] = 1'b0;
      if (p == 0 && (d == 1 || d == 3)) begin
         m_dir[ch] = (d == 1);
         if (!press) begin
            m_evt[ch]++;
            if (d == 1) m_cnt[ch] = M0_MIN + (m_cnt[ch] - M0_MIN + M0_STEP) % M0_RANGE;
            else m_cnt[ch] = M0_MIN + ((m_cnt[ch] - M0_MIN - M0_STEP) % M0_RANGE + M0_RANGE) % M0_RANGE;
         end
      end
      if (press) m_cnt[ch] = M0_RST;
      m_pos[ch] = p;
   endtask

   // Full detent on u_dut2 channel 0 with latency check on the final pin change.
   task automatic detent2(input bit up, input int exp_old, input int exp_new);
      logic [1:0] ab;
      for (int i = 0; i < 4; i++) begin
         ab = ab_of(up ? (i + 1) : (3 - i));
         a2[0] = ab[1];
         b2[0] = ab[0];
         if (i < 3) tick(24);
      end
      tick(19);
      tests++;
      if (cnt2[7:0] !== 8'(exp_old) || evt2[0] !== 1'b0) begin
         fails++;
         $display("FAIL db_latency_early: got cnt=%0d evt=%b expected cnt=%0d evt=0", cnt2[7:0], evt2[0], exp_old);
      end
      tick(1);
      tests++;
      if (cnt2[7:0] !== 8'(exp_new) || evt2[0] !== 1'b1) begin
         fails++;
         $display("FAIL db_latency_edge: got cnt=%0d evt=%b expected cnt=%0d evt=1", cnt2[7:0], evt2[0], exp_new);
      end
      tick(4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a0 = '0; b0 = '0; btn0 = '1;
      a1 = '0; b1 = '0; btn1 = '1;
      a2 = '0; b2 = '0; btn2 = '1;
      sel0 = 3'd0; sel1 = 3'd0; sel2 = 3'd0;
      for (int ch = 0; ch < 2; ch++) begin
         m_cnt[ch] = M0_RST; m_pos[ch] = 0; m_evt[ch] = 0; m_dir[ch] = 1'b0;
      end
      tick(3);
      tests++;
      if (cnt0 !== {8'(M0_RST), 8'(M0_RST)}) begin fails++; $display("FAIL reset_cnt0: got %h expected %h", cnt0, {8'(M0_RST), 8'(M0_RST)}); end
      tests++;
      if (cnt1 !== 16'h0000 || cnt2 !== 16'h0000) begin fails++; $display("FAIL reset_cnt12: got %h %h expected 0000 0000", cnt1, cnt2); end
      tests++;
      if (evt0 !== 2'b00 || evt1 !== 2'b00 || evt2 !== 2'b00) begin fails++; $display("FAIL reset_evt: got %b %b %b expected 00", evt0, evt1, evt2); end
      tests++;
      if (dir0 !== 2'b00 || dir1 !== 2'b00) begin fails++; $display("FAIL reset_dir: got %b %b expected 00", dir0, dir1); end
      tests++;
      if (bo0 !== 2'b00 || bo1 !== 2'b00 || bo2 !== 2'b00) begin fails++; $display("FAIL reset_btn: got %b %b %b expected 00", bo0, bo1, bo2); end
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_detent_x1();
      drive0(0, 1, 0); tick(5);
      drive0(0, 2, 0); tick(5);
      drive0(0, 3, 0); tick(5);
      tests++;
      if (evt0[0] !== 1'b0 || cnt0[7:0] !== 8'(M0_RST)) begin fails++; $display("FAIL x1_no_mid_event: got evt=%b cnt=%0d expected evt=0 cnt=%0d", evt0[0], cnt0[7:0], M0_RST); end
      drive0(0, 0, 0);
      tick(3);
      tests++;
      if (cnt0[7:0] !== 8'(M0_RST) || evt0[0] !== 1'b0) begin fails++; $display("FAIL x1_edge3: got cnt=%0d evt=%b expected cnt=%0d evt=0", cnt0[7:0], evt0[0], M0_RST); end
      tick(1);
      tests++;
      if (cnt0[7:0] !== 8'(m_cnt[0]) || evt0[0] !== 1'b1 || dir0[0] !== 1'b1) begin
         fails++; $display("FAIL x1_up_edge4: got cnt=%0d evt=%b dir=%b expected cnt=%0d evt=1 dir=1", cnt0[7:0], evt0[0], dir0[0], m_cnt[0]);
      end
      tick(1);
      tests++;
      if (evt0[0] !== 1'b0) begin fails++; $display("FAIL x1_evt_one_cycle: got %b expected 0", evt0[0]); end
      for (int p = 3; p >= 0; p--) begin
         drive0(0, p, 0);
         tick(5);
      end
      tests++;
      if (cnt0[7:0] !== 8'(m_cnt[0]) || dir0[0] !== 1'b0) begin fails++; $display("FAIL x1_down: got cnt=%0d dir=%b expected cnt=%0d dir=0", cnt0[7:0], dir0[0], m_cnt[0]); end
   endtask

   task automatic test_x4_wrap();
      int seq[8] = '{3, 2, 1, 0, 1, 2, 3, 0};
      int exp_c = 0;
      logic [1:0] ab;
      for (int i = 0; i < 8; i++) begin
         exp_c = (i < 4) ? (exp_c + 255) % 256 : (exp_c + 1) % 256;
         ab = ab_of(seq[i]);
         a1[0] = ab[1];
         b1[0] = ab[0];
         tick(4);
         tests++;
         if (cnt1[7:0] !== 8'(exp_c) || evt1[0] !== 1'b1 || dir1[0] !== (i >= 4)) begin
            fails++; $display("FAIL x4_step%0d: got cnt=%0d evt=%b dir=%b expected cnt=%0d evt=1 dir=%0d", i, cnt1[7:0], evt1[0], dir1[0], exp_c, i >= 4);
         end
         tick(2);
      end
      tests++;
      if (cnt1[15:8] !== 8'h00 || led1 !== 8'(exp_c)) begin fails++; $display("FAIL x4_other_led: got ch1=%0d led=%0d expected ch1=0 led=%0d", cnt1[15:8], led1, exp_c); end
   endtask

   task automatic test_saturate();
      int e = 0;
      int en;
      for (int k = 0; k < 5; k++) begin
         en = (e + 3 > 10) ? 10 : e + 3;
         detent2(1'b1, e, en);
         e = en;
      end
      tests++;
      if (dir2[0] !== 1'b1 || led2 !== 8'(e)) begin fails++; $display("FAIL sat_dir_led: got dir=%b led=%0d expected dir=1 led=%0d", dir2[0], led2, e); end
   endtask

   task automatic test_debounce();
      int s;
      s = seen2;
      a2[0] = 1'b1; tick(10);
      a2[0] = 1'b0; tick(30);
      tests++;
      if (seen2 !== s || cnt2[7:0] !== 8'd10) begin fails++; $display("FAIL db_glitch_a: got evts=%0d cnt=%0d expected evts=%0d cnt=10", seen2, cnt2[7:0], s); end
      detent2(1'b0, 10, 7);
      btn2[0] = 1'b0; tick(10);
      btn2[0] = 1'b1; tick(30);
      tests++;
      if (bo2[0] !== 1'b0 || cnt2[7:0] !== 8'd7) begin fails++; $display("FAIL db_glitch_btn: got btn=%b cnt=%0d expected btn=0 cnt=7", bo2[0], cnt2[7:0]); end
      btn2[0] = 1'b0;
      tick(19);
      tests++;
      if (bo2[0] !== 1'b1 || cnt2[7:0] !== 8'd7) begin fails++; $display("FAIL db_btn_accept: got btn=%b cnt=%0d expected btn=1 cnt=7", bo2[0], cnt2[7:0]); end
      tick(1);
      tests++;
      if (cnt2[7:0] !== 8'd0 || evt2[0] !== 1'b0) begin fails++; $display("FAIL db_btn_reload: got cnt=%0d evt=%b expected cnt=0 evt=0", cnt2[7:0], evt2[0]); end
      btn2[0] = 1'b1;
      tick(24);
   endtask

   task automatic test_button_wins();
      while (m_cnt[1] != 37) begin
         for (int p = 1; p <= 4; p++) begin
            drive0(1, p % 4, 0);
            tick(5);
         end
      end
      for (int p = 1; p <= 3; p++) begin
         drive0(0, p, 0);
         drive0(1, p, 0);
         tick(5);
      end
      tests++;
      if (cnt0[15:8] !== 8'd37) begin fails++; $display("FAIL btn_pre37: got %0d expected 37", cnt0[15:8]); end
      drive0(1, 0, 1);
      drive0(0, 0, 0);
      tick(3);
      tests++;
      if (bo0[1] !== 1'b1) begin fails++; $display("FAIL btn_level: got %b expected 1", bo0[1]); end
      tick(1);
      tests++;
      if (cnt0[15:8] !== 8'(m_cnt[1]) || evt0[1] !== 1'b0 || dir0[1] !== m_dir[1]) begin
         fails++; $display("FAIL btn_wins: got cnt=%0d evt=%b dir=%b expected cnt=%0d evt=0 dir=%b", cnt0[15:8], evt0[1], dir0[1], m_cnt[1], m_dir[1]);
      end
      tests++;
      if (cnt0[7:0] !== 8'(m_cnt[0]) || evt0[0] !== 1'b1) begin fails++; $display("FAIL btn_ch0_indep: got cnt=%0d evt=%b expected cnt=%0d evt=1", cnt0[7:0], evt0[0], m_cnt[0]); end
      btn0[1] = 1'b1;
      tick(5);
      tests++;
      if (bo0[1] !== 1'b0 || cnt0[15:8] !== 8'(m_cnt[1])) begin fails++; $display("FAIL btn_release: got btn=%b cnt=%0d expected btn=0 cnt=%0d", bo0[1], cnt0[15:8], m_cnt[1]); end
   endtask

   task automatic test_random();
      int ch, r, np;
      bit pr;
      for (int it = 0; it < 300; it++) begin
         ch = $urandom_range(0, 1);
         r  = $urandom_range(0, 9);
         if (r < 4)       np = (m_pos[ch] + 1) % 4;
         else if (r < 8)  np = (m_pos[ch] + 3) % 4;
         else if (r == 8) np = (m_pos[ch] + 2) % 4;
         else             np = m_pos[ch];
         pr = ($urandom_range(0, 15) == 0);
         drive0(ch, np, pr);
         tick(5);
         if (pr) begin
            btn0[ch] = 1'b1;
            tick(5);
         end
         tests++;
         if (cnt0 !== {8'(m_cnt[1]), 8'(m_cnt[0])}) begin
            fails++; $display("FAIL rand_cnt it=%0d: got %h expected %h", it, cnt0, {8'(m_cnt[1]), 8'(m_cnt[0])});
         end
      end
      for (int c = 0; c < 2; c++) begin
         tests++;
         if (seen0[c] !== m_evt[c] || dir0[c] !== m_dir[c]) begin
            fails++; $display("FAIL rand_evt_dir ch%0d: got evts=%0d dir=%b expected evts=%0d dir=%b", c, seen0[c], dir0[c], m_evt[c], m_dir[c]);
         end
      end
   endtask

   task automatic test_led_and_reset();
      int p1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 1; p <= 4; p++) begin
            drive0(1, (m_pos[1] + 1) % 4, 0);
            tick(5);
         end
      end
      sel0 = 3'd1; #1;
      tests++;
      if (led0 !== 8'(m_cnt[1])) begin fails++; $display("FAIL led_sel1: got %0d expected %0d", led0, m_cnt[1]); end
      sel0 = 3'd0; #1;
      tests++;
      if (led0 !== 8'(m_cnt[0])) begin fails++; $display("FAIL led_sel0: got %0d expected %0d", led0, m_cnt[0]); end
      sel0 = 3'd7; #1;
      tests++;
      if (led0 !== 8'h00) begin fails++; $display("FAIL led_sel7: got %0d expected 0", led0); end
      sel0 = 3'd2; #1;
      tests++;
      if (led0 !== 8'h00) begin fails++; $display("FAIL led_sel2: got %0d expected 0", led0); end
      drive0(0, 0, 0); tick(5);
      drive0(0, 1, 0); tick(5);
      drive0(0, 2, 0); tick(5);
      rst_n = 1'b0;
      tick(2);
      tests++;
      if (cnt0 !== {8'(M0_RST), 8'(M0_RST)} || cnt1 !== 16'h0000 || cnt2 !== 16'h0000 || evt0 !== 2'b00) begin
         fails++; $display("FAIL midseq_reset: got %h %h %h evt=%b expected %h 0000 0000 evt=00", cnt0, cnt1, cnt2, evt0, {8'(M0_RST), 8'(M0_RST)});
      end
      rst_n = 1'b1;
      p1 = m_pos[1];
      for (int c = 0; c < 2; c++) begin m_cnt[c] = M0_RST; m_pos[c] = 0; m_dir[c] = 1'b0; end
      drive0(0, 2, 0);
      drive0(1, p1, 0);
      tick(10);
      tests++;
      if (seen0[0] !== m_evt[0] || seen0[1] !== m_evt[1] || cnt0 !== {8'(m_cnt[1]), 8'(m_cnt[0])}) begin
         fails++; $display("FAIL post_reset_quiet: got evts=%0d/%0d cnt=%h expected evts=%0d/%0d cnt=%h", seen0[0], seen0[1], cnt0, m_evt[0], m_evt[1], {8'(m_cnt[1]), 8'(m_cnt[0])});
      end
      drive0(0, 3, 0); tick(5);
      drive0(0, 0, 0); tick(5);
      tests++;
      if (cnt0[7:0] !== 8'(m_cnt[0]) || dir0[0] !== m_dir[0]) begin fails++; $display("FAIL post_reset_detent: got cnt=%0d dir=%b expected cnt=%0d dir=%b", cnt0[7:0], dir0[0], m_cnt[0], m_dir[0]); end
   endtask

   initial begin
      test_reset();
      test_detent_x1();
      test_x4_wrap();
      test_saturate();
      test_debounce();
      test_button_wins();
      test_random();
      test_led_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
